// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined IEEE-754 multiplier with DAZ/FTZ and tag pass-through
module fp_mul_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int TW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [EW+MW:0] in1,
  input  logic [EW+MW:0] in2,
  input  logic [2:0]     round_m,
  input  logic [TW-1:0]  tag_in,
  output logic           out_valid,
  output logic [EW+MW:0] out,
  output logic [TW-1:0]  tag_out,
  output logic           ov,
  output logic           un,
  output logic           inv,
  output logic           inexact
);

  localparam int XW = EW + 2;
  localparam int PW = 2 * (MW + 1);
  localparam logic [XW-1:0]  C_BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic [XW-1:0]  C_EMAX = XW'((1 << EW) - 1);
  localparam logic [EW+MW:0] C_QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  // Stage 1: classify, resolve special results early, form exponent sum and mantissa product
  logic [EW-1:0]  w1_ea, w1_eb;
  logic [MW-1:0]  w1_fa, w1_fb;
  logic           w1_a_zero, w1_b_zero, w1_a_inf, w1_b_inf;
  logic           w1_a_nan, w1_b_nan, w1_a_snan, w1_b_snan;
  logic           w1_sign, w1_inv, w1_spec;
  logic [EW+MW:0] w1_spec_val;
  logic [XW-1:0]  w1_exp;
  logic [PW-1:0]  w1_prod;

  assign w1_ea     = in1[EW+MW-1:MW];
  assign w1_eb     = in2[EW+MW-1:MW];
  assign w1_fa     = in1[MW-1:0];
  assign w1_fb     = in2[MW-1:0];
  assign w1_a_zero = (w1_ea == '0);
  assign w1_b_zero = (w1_eb == '0);
  assign w1_a_inf  = (&w1_ea) && (w1_fa == '0);
  assign w1_b_inf  = (&w1_eb) && (w1_fb == '0);
  assign w1_a_nan  = (&w1_ea) && (w1_fa != '0);
  assign w1_b_nan  = (&w1_eb) && (w1_fb != '0);
  assign w1_a_snan = w1_a_nan && !w1_fa[MW-1];
  assign w1_b_snan = w1_b_nan && !w1_fb[MW-1];
  assign w1_sign   = in1[EW+MW] ^ in2[EW+MW];
  assign w1_inv    = w1_a_snan | w1_b_snan | (w1_a_inf & w1_b_zero) | (w1_a_zero & w1_b_inf);
  assign w1_exp    = {2'b00, w1_ea} + {2'b00, w1_eb} - C_BIAS;
  assign w1_prod   = {{(MW+1){1'b0}}, 1'b1, w1_fa} * {{(MW+1){1'b0}}, 1'b1, w1_fb};

  always_comb begin
    w1_spec     = 1'b1;
    w1_spec_val = C_QNAN;
    if (w1_a_nan || w1_b_nan || w1_inv)
      w1_spec_val = C_QNAN;
    else if (w1_a_inf || w1_b_inf)
      w1_spec_val = {w1_sign, {EW{1'b1}}, {MW{1'b0}}};
    else if (w1_a_zero || w1_b_zero)
      w1_spec_val = {w1_sign, {(EW+MW){1'b0}}};
    else
      w1_spec = 1'b0;
  end

  logic           r1_valid, r1_sign, r1_spec, r1_inv;
  logic [XW-1:0]  r1_exp;
  logic [PW-1:0]  r1_prod;
  logic [EW+MW:0] r1_spec_val;
  logic [2:0]     r1_rm;
  logic [TW-1:0]  r1_tag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_valid <= 1'b0;
    end else begin
      r1_valid <= in_valid;
    end
    r1_sign     <= w1_sign;
    r1_spec     <= w1_spec;
    r1_inv      <= w1_inv;
    r1_exp      <= w1_exp;
    r1_prod     <= w1_prod;
    r1_spec_val <= w1_spec_val;
    r1_rm       <= round_m;
    r1_tag      <= tag_in;
  end

  // Stage 2: product lies in [1,4); a set MSB means shift right by one and bump the exponent
  logic          w2_norm, w2_guard, w2_sticky;
  logic [MW:0]   w2_mant;
  logic [XW-1:0] w2_exp;

  assign w2_norm   = r1_prod[PW-1];
  assign w2_mant   = w2_norm ? r1_prod[PW-1:MW+1] : r1_prod[PW-2:MW];
  assign w2_guard  = w2_norm ? r1_prod[MW] : r1_prod[MW-1];
  assign w2_sticky = w2_norm ? (|r1_prod[MW-1:0]) : (|r1_prod[MW-2:0]);
  assign w2_exp    = r1_exp + {{(XW-1){1'b0}}, w2_norm};

  logic           r2_valid, r2_sign, r2_spec, r2_inv, r2_guard, r2_sticky;
  logic [XW-1:0]  r2_exp;
  logic [MW:0]    r2_mant;
  logic [EW+MW:0] r2_spec_val;
  logic [2:0]     r2_rm;
  logic [TW-1:0]  r2_tag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r2_valid <= 1'b0;
    end else begin
      r2_valid <= r1_valid;
    end
    r2_sign     <= r1_sign;
    r2_spec     <= r1_spec;
    r2_inv      <= r1_inv;
    r2_guard    <= w2_guard;
    r2_sticky   <= w2_sticky;
    r2_exp      <= w2_exp;
    r2_mant     <= w2_mant;
    r2_spec_val <= r1_spec_val;
    r2_rm       <= r1_rm;
    r2_tag      <= r1_tag;
  end

  // Stage 3: round, then substitute overflow/underflow results
  logic           w3_inc, w3_to_inf, w3_carry, w3_of, w3_uf, w3_gs;
  logic [MW+1:0]  w3_sum;
  logic [MW-1:0]  w3_frac;
  logic [XW-1:0]  w3_exp;
  logic [EW+MW:0] w3_res;
  logic           w3_ov, w3_un, w3_inv, w3_inx;

  assign w3_gs = r2_guard | r2_sticky;

  always_comb begin
    w3_inc    = r2_guard & (r2_sticky | r2_mant[0]);
    w3_to_inf = 1'b1;
    case (r2_rm)
      3'b001: begin w3_inc = 1'b0;              w3_to_inf = 1'b0;     end
      3'b010: begin w3_inc = r2_sign & w3_gs;   w3_to_inf = r2_sign;  end
      3'b011: begin w3_inc = !r2_sign & w3_gs;  w3_to_inf = !r2_sign; end
      3'b100: begin w3_inc = r2_guard;          w3_to_inf = 1'b1;     end
      default: ;
    endcase
  end

  assign w3_sum   = {1'b0, r2_mant} + {{(MW+1){1'b0}}, w3_inc};
  assign w3_carry = w3_sum[MW+1];
  assign w3_frac  = w3_carry ? w3_sum[MW:1] : w3_sum[MW-1:0];
  assign w3_exp   = r2_exp + {{(XW-1){1'b0}}, w3_carry};
  assign w3_of    = !w3_exp[XW-1] && (w3_exp >= C_EMAX);
  assign w3_uf    = w3_exp[XW-1] || (w3_exp == '0);

  always_comb begin
    w3_res = {r2_sign, w3_exp[EW-1:0], w3_frac};
    w3_ov  = 1'b0;
    w3_un  = 1'b0;
    w3_inv = 1'b0;
    w3_inx = w3_gs;
    if (r2_spec) begin
      w3_res = r2_spec_val;
      w3_inv = r2_inv;
      w3_inx = 1'b0;
    end else if (w3_of) begin
      w3_res = w3_to_inf ? {r2_sign, {EW{1'b1}}, {MW{1'b0}}}
                         : {r2_sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
      w3_ov  = 1'b1;
      w3_inx = 1'b1;
    end else if (w3_uf) begin
      w3_res = {r2_sign, {(EW+MW){1'b0}}};
      w3_un  = 1'b1;
      w3_inx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      tag_out   <= '0;
      ov        <= 1'b0;
      un        <= 1'b0;
      inv       <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        out     <= w3_res;
        tag_out <= r2_tag;
        ov      <= w3_ov;
        un      <= w3_un;
        inv     <= w3_inv;
        inexact <= w3_inx;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard bench for fp_mul_pipe (single and half precision)
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [2:0]  round_m = '0;
  logic [3:0]  tag_in = '0;
  logic        out_valid, ov, un, inv, inexact;
  logic [31:0] out;
  logic [3:0]  tag_out;

  logic        h_in_valid = 1'b0;
  logic [15:0] h_in1 = '0, h_in2 = '0;
  logic [2:0]  h_round_m = '0;
  logic [3:0]  h_tag_in = '0;
  logic        h_out_valid, h_ov, h_un, h_inv, h_inexact;
  logic [15:0] h_out;
  logic [3:0]  h_tag_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] next_tag = '0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EW(8), .MW(23), .TW(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in1(in1), .in2(in2),
    .round_m(round_m), .tag_in(tag_in), .out_valid(out_valid), .out(out),
    .tag_out(tag_out), .ov(ov), .un(un), .inv(inv), .inexact(inexact)
  );

  fp_mul_pipe #(.EW(5), .MW(10), .TW(4)) u_half (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in1(h_in1), .in2(h_in2),
    .round_m(h_round_m), .tag_in(h_tag_in), .out_valid(h_out_valid), .out(h_out),
    .tag_out(h_tag_out), .ov(h_ov), .un(h_un), .inv(h_inv), .inexact(h_inexact)
  );

  // Scoreboard monitor: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output out=%h tag=%0d required=none", out, tag_out);
      end else begin
        mon_e = sb.pop_front();
        if (out !== mon_e.res) begin
          errors++;
          $display("FAIL result tag=%0d got=%h required=%h", mon_e.tag, out, mon_e.res);
        end
        checks++;
        if ({ov, un, inv, inexact} !== mon_e.flg) begin
          errors++;
          $display("FAIL flags tag=%0d got=%b required=%b", mon_e.tag, {ov, un, inv, inexact}, mon_e.flg);
        end
        checks++;
        if (tag_out !== mon_e.tag) begin
          errors++;
          $display("FAIL tag got=%0d required=%0d", tag_out, mon_e.tag);
        end
      end
    end
  end

  // Caller aligns to a negedge first; flags are {ov,un,inv,inexact}
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [31:0] res, input logic [3:0] flg, input bit track);
    exp_t e;
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    round_m  = rm;
    tag_in   = next_tag;
    if (track) begin
      e.res = res;
      e.flg = flg;
      e.tag = next_tag;
      sb.push_back(e);
    end
    next_tag = next_tag + 4'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in1 = 32'h3F800000;
    in2 = 32'h3F800000;
    repeat (4) @(negedge clk);
    checks++;
    if ({out_valid, ov, un, inv, inexact} !== 5'b0 || out !== 32'h0 || tag_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got=%b/%h/%h required=00000/0/0",
               {out_valid, ov, un, inv, inexact}, out, tag_out);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst = 1'b1;
    drive(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_c1 got=%b required=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_c2 got=%b required=0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'h40400000) begin
      errors++;
      $display("FAIL latency_c3 got=%b/%h required=1/40400000", out_valid, out);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 32'h40400000) begin
      errors++;
      $display("FAIL hold got=%b/%h required=0/40400000", out_valid, out);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [26] = '{
      32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h7F000000,
      32'h7F800000, 32'h7FA00000, 32'h00800000, 32'hC0000000, 32'h80000000,
      32'h00400000, 32'h7F800000, 32'h7FC00001, 32'hBF800001, 32'h3F800003,
      32'h3F800003, 32'h7F000000, 32'hFF000000, 32'hFF000000, 32'h80800000,
      32'h3FFFFFFE, 32'h3FFFFFFE, 32'h7FC00000, 32'h3F800003, 32'h00400000,
      32'h3FFFFFFE};
    logic [31:0] vb [26] = '{
      32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h7F000000,
      32'h00000000, 32'h3F800000, 32'h3F000000, 32'h40400000, 32'h3F800000,
      32'h40000000, 32'hC0000000, 32'h3F800000, 32'h3F800001, 32'h3FC00000,
      32'h3FC00000, 32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h3F000000,
      32'h3F800001, 32'h3F800001, 32'h7FA00000, 32'h3FC00000, 32'h7F800000,
      32'h3F800001};
    logic [2:0] vm [26] = '{
      3'd0, 3'd3, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
      3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd4, 3'd2, 3'd3, 3'd4, 3'd0,
      3'd0, 3'd1, 3'd0, 3'd7, 3'd0, 3'd3};
    logic [31:0] vr [26] = '{
      32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h7F800000, 32'h7F7FFFFF,
      32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'hC0C00000, 32'h80000000,
      32'h00000000, 32'hFF800000, 32'h7FC00000, 32'hBF800003, 32'h3FC00004,
      32'h3FC00005, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 32'h80000000,
      32'h40000000, 32'h3FFFFFFF, 32'h7FC00000, 32'h3FC00004, 32'h7FC00000,
      32'h40000000};
    logic [3:0] vf [26] = '{
      4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b1001,
      4'b0010, 4'b0010, 4'b0101, 4'b0000, 4'b0000,
      4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
      4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b0101,
      4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0010,
      4'b0001};
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(va[i], vb[i], vm[i], vr[i], vf[i], 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] vout [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                              32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    next_tag = 4'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 8) drive(vin[k], 32'h40000000, 3'(k % 5), vout[k], 4'b0000, 1'b1);
      else in_valid = 1'b0;
      if (k >= 3) begin
        checks++;
        if (k < 11 && (out_valid !== 1'b1 || tag_out !== 4'(k - 3))) begin
          errors++;
          $display("FAIL b2b_slot%0d got=%b/%0d required=1/%0d", k, out_valid, tag_out, k - 3);
        end else if (k == 11 && out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_tail got=%b required=0", out_valid);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_flush();
    next_tag = 4'd8;
    @(negedge clk); drive(32'h40000000, 32'h40000000, 3'd0, 32'h40800000, 4'b0000, 1'b1);
    @(negedge clk); drive(32'h40400000, 32'h40000000, 3'd0, 32'h0, 4'b0, 1'b0);
    @(negedge clk); drive(32'h40800000, 32'h40000000, 3'd0, 32'h0, 4'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, ov, un, inv, inexact} !== 5'b0 || out !== 32'h0 || tag_out !== 4'h0) begin
      errors++;
      $display("FAIL flush_clear got=%b/%h/%h required=00000/0/0",
               {out_valid, ov, un, inv, inexact}, out, tag_out);
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_cycle%0d got=%b required=0", k, out_valid);
      end
    end
  endtask

  task automatic test_half();
    logic [15:0] ha [2] = '{16'h3C00, 16'h7BFF};
    logic [15:0] hb [2] = '{16'h4000, 16'h7BFF};
    logic [15:0] hr [2] = '{16'h4000, 16'h7C00};
    logic [3:0]  hf [2] = '{4'b0000, 4'b1001};
    bit seen;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      h_in_valid = 1'b1;
      h_in1 = ha[i];
      h_in2 = hb[i];
      h_round_m = 3'd0;
      h_tag_in = 4'(i + 3);
      @(negedge clk);
      h_in_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        if (h_out_valid === 1'b1) seen = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL half%0d_timeout got=no_valid required=valid", i);
      end else if (h_out !== hr[i] || {h_ov, h_un, h_inv, h_inexact} !== hf[i] || h_tag_out !== 4'(i + 3)) begin
        errors++;
        $display("FAIL half%0d got=%h/%b/%0d required=%h/%b/%0d", i, h_out,
                 {h_ov, h_un, h_inv, h_inexact}, h_tag_out, hr[i], hf[i], i + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_flush();
    test_half();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EW, default 8: exponent field width, legal range 5..11.
REQ-002 Parameter MW, default 23: stored fraction width, legal range 10..52; the total word width is W = 1+EW+MW.
REQ-003 Parameter TW, default 4: width of the user tag carried alongside each operation.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  operation request; in1, in2, round_m and tag_in are sampled when this is high.
REQ-007 in1, in2  input  W  IEEE-754-format operands.
REQ-008 round_m  input  3  rounding mode: 000 RNe, 001 RZ, 010 RD, 011 RU, 100 RNa; codes 101-111 behave as RNe.
REQ-009 tag_in  input  TW  user tag.
REQ-010 out_valid  output  1  result qualifier.
REQ-011 out  output  W  product.
REQ-012 tag_out  output  TW  tag of the operation now presented.
REQ-013 ov, un, inv, inexact  output  1 each  exception flags, qualified by out_valid.

Function
REQ-014 The block SHALL be a 3-stage pipeline that accepts one operation per cycle with no backpressure.
- Stage 1: classify operands and compute the mantissa product.
- Stage 2: normalise and compute guard/round/sticky bits.
- Stage 3: round and pack the result.
REQ-015 out_valid SHALL be high exactly 3 cycles after each cycle in which in_valid was sampled high, with no bubbles inserted.
REQ-016 When out_valid is low, out, tag_out and all flags SHALL hold their previous values.
REQ-017 Result sign SHALL be the XOR of the operand signs for every result, including zeros, infinities and overflow results; the only exception is the canonical NaN in REQ-019.
REQ-018 Classification SHALL decode each operand as zero, subnormal, normal, inf, qNaN or sNaN; subnormal inputs SHALL be treated as zero (DAZ).
REQ-019 Invalid cases are inf*0, 0*inf and any sNaN operand; these SHALL produce the canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0) with inv=1.
REQ-020 A qNaN operand without any sNaN present SHALL produce the canonical qNaN with inv=0.
REQ-021 inf*finite-nonzero and inf*inf SHALL produce a signed inf with all flags 0.
REQ-022 A zero operand (after DAZ) with a finite other operand SHALL produce a signed zero with all flags 0.
REQ-023 Unbiased exponent arithmetic SHALL use EW+2 bits signed so that no intermediate wraps.
REQ-024 The mantissa product SHALL be 2(MW+1) bits; normalisation SHALL apply a 1-bit right shift with exponent+1 when the product MSB is set.
REQ-025 Guard is the bit below the result LSB; sticky is the OR of all remaining lower bits.
REQ-026 Rounding rules:
- RNe increments on guard&(sticky|lsb).
- RNa increments on guard.
- RZ never increments.
- RU increments on (guard|sticky) for positive results.
- RD increments on (guard|sticky) for negative results.
REQ-027 A rounding carry out of the mantissa SHALL increment the exponent.
REQ-028 inexact SHALL equal guard|sticky, evaluated before any overflow/underflow substitution.
REQ-029 Overflow occurs when the rounded biased exponent is >= 2^EW-1; it SHALL set ov=1 and inexact=1.
- Result is inf for RNe and RNa, for RU when positive and for RD when negative.
- Result is the largest finite magnitude otherwise.
REQ-030 Underflow occurs when the rounded biased exponent is <= 0; it SHALL produce a signed zero (FTZ) with un=1 and inexact=1.
REQ-031 inv, ov and un SHALL be mutually exclusive.
REQ-032 tag_out SHALL equal the tag_in of the same operation.

Reset
REQ-033 While rst=0 at a rising edge, all pipeline valid bits, out_valid, out, tag_out, ov, un, inv and inexact SHALL be cleared to 0.
REQ-034 Operations in flight when reset is asserted SHALL be discarded and never emerge.
REQ-035 An in_valid sampled in the first cycle with rst=1 SHALL be accepted normally.

Verification
REQ-036 in1=0x3FC00000, in2=0x40000000, RNe -> 3 cycles later out=0x40400000 with all flags 0.
REQ-037 in1=in2=0x3F800001:
- RNe -> out=0x3F800002, inexact=1.
- RU -> 0x3F800003.
- RZ -> 0x3F800002.
REQ-038 in1=in2=0x7F000000:
- RNe -> out=0x7F800000, ov=1, inexact=1.
- RZ -> out=0x7F7FFFFF, ov=1.
REQ-039 0x7F800000*0x00000000 -> out=0x7FC00000, inv=1; 0x7FA00000*0x3F800000 -> 0x7FC00000, inv=1; 0x00800000*0x3F000000 -> 0x00000000, un=1, inexact=1.
REQ-040 Back-to-back streams, reset and parameters:
- 8 consecutive operations with tags 0..7 emerge in order on 8 consecutive cycles.
- Reset asserted one cycle after the 3rd issue yields no out_valid afterwards.
- EW=5, MW=10: 0x3C00*0x4000 -> 0x4000.
